serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial add/subtract controller. It sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first, with a registered carry between bits. It exposes a start/busy/done handshake and sits between a register-file or test-harness master and the shared full-adder datapath. It trades latency for area in the lab arithmetic experiments.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced to 1, cin ignored); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result.
- cout  output  1  final carry-out (for sub: 1 = no borrow).

## Operation
- Reset: one clock; asynchronous, active-low, fixed polarity and synchronicity.
- State machine, 3 states:
  - IDLE: on start=1, load a_sh←a, b_sh←(op_sub ? ~b : b), carry←(op_sub ? 1 : cin), cnt←0, sum_sh←0 → RUN. start=0 stays in IDLE.
  - RUN: each cycle the full-adder cell computes s,c from a_sh[0], b_sh[0], carry. Then carry←c, sum_sh←{s, sum_sh[WIDTH-1:1]}, a_sh and b_sh shift right by 1, cnt←cnt+1. When cnt==WIDTH-1 in this cycle → DONE.
  - DONE: done=1, then → IDLE unconditionally.
- sum drives sum_sh; cout drives carry. Both hold their value from DONE until the next accepted start. On acceptance they begin changing (sum_sh cleared at load).
- start in RUN or DONE is ignored, not queued. start in the DONE cycle is also ignored; a new request needs IDLE.
- Operand inputs are don't-care except in the cycle where start is accepted.
- Arithmetic is modulo 2^WIDTH. cnt width is clog2(WIDTH); cnt never wraps, because the exit is taken at WIDTH-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, all internal registers 0.
- Start accepted at rising edge E0. Bit i is processed at edge E(i+1), i=0..WIDTH-1.
- State is DONE after edge E(WIDTH); done=1 and sum/cout are final for that cycle only.
- Back in IDLE after edge E(WIDTH+1).
- Start-to-done latency is WIDTH cycles. Minimum request-to-request spacing is WIDTH+2 cycles.
- busy rises after E0 and falls after E(WIDTH+1).
- rst_n low at any point, including mid-RUN or in DONE: immediate return to reset values. The partial result is discarded, and no done pulse is produced for the aborted operation.
- Full-adder cell is purely combinational inside the RUN cycle; there is no extra pipeline stage.

## Structure
- Shared package arith_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding;
  - localparam CNT_W = clog2(WIDTH) helper.
- One sub-module is natural: fa_cell (1-bit full adder: inputs x, y, ci; outputs s, co), instantiated once. The controller holds only the FSM, shift registers, carry flop and counter.

## Test plan
(WIDTH=8 unless noted)
- a=0x35, b=0x4A, cin=0, op_sub=0 → done exactly 8 cycles after the start edge; sum=0x7F, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (full carry ripple across all bits). Repeat with cin=1 → sum=0x01, cout=1.
- op_sub=1, a=0x10, b=0x20, cin=1 → sum=0xF0, cout=0 (borrow; cin ignored). Then a=0x20, b=0x10 → sum=0x10, cout=1.
- start pulsed in RUN (cycle 3) and again in the DONE cycle with different operands → ignored. Exactly one done; result equals the first request. sum/cout hold until the next start from IDLE.
- rst_n pulsed low at cycle 4 of RUN → busy=0, sum=0, cout=0 immediately, no done. A following start with a=0x01, b=0x02 → sum=0x03 after 8 cycles.
- WIDTH=4, exhaustive: all a, b, cin, op_sub combinations back-to-back at minimum spacing → sum/cout match a reference model every time.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic controller.
package arith_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that must hold 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between the master and the serial adder controller.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder shared by the serial controller.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    // Purely combinational sum and carry.
    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
    end
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one bit per clock, LSB first.
module serial_adder_ctrl
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // FSM, operand shifters, carry flop, counter and registered handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q   <= bus.a;
                        b_sh_q   <= bus.op_sub ? ~bus.b : bus.b;
                        carry_q  <= bus.op_sub ? 1'b1 : bus.cin;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    carry_q  <= fa_co;
                    sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_sh_q;
    assign bus.cout = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 directed, WIDTH=4 exhaustive).
module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;
    int   nchk;
    int   npass;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 request from IDLE, observed for 20 cycles after acceptance.
    // With glitch set, extra starts are driven in RUN (cycle 3) and in DONE.
    task automatic run8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic ec,
                        input bit glitch, input string tag);
        int donec, dk, busyc;
        logic [7:0] sd;
        logic cd;
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sub = sub; bus8.a = a; bus8.b = b; bus8.cin = ci;
        @(negedge clk);
        bus8.start = 1'b0; bus8.op_sub = ~sub; bus8.a = 8'hC3; bus8.b = 8'h3C; bus8.cin = ~ci;
        donec = 0; dk = -1; busyc = 0; sd = '0; cd = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (bus8.busy) busyc++;
            if (bus8.done) begin
                donec++; dk = j; sd = bus8.sum; cd = bus8.cout;
            end
            if (glitch && (j == 3 || j == 8)) begin
                bus8.start = 1'b1; bus8.op_sub = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
            end
            if (glitch && (j == 4 || j == 9)) bus8.start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_done_count"}, donec, 1);
        chk({tag, "_done_cycle"}, dk, 8);
        chk({tag, "_busy_cycles"}, busyc, 9);
        chk({tag, "_sum_at_done"}, sd, es);
        chk({tag, "_cout_at_done"}, cd, ec);
        chk({tag, "_sum_hold"}, bus8.sum, es);
        chk({tag, "_cout_hold"}, bus8.cout, ec);
        chk({tag, "_busy_idle"}, bus8.busy, 0);
    endtask

    initial begin
        logic [4:0] r;
        logic [3:0] av, bv;
        int donec;
        nchk = 0; npass = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.op_sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.op_sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_sum", bus8.sum, 0);
        chk("rst_cout", bus8.cout, 0);
        chk("rst4_all", {bus4.busy, bus4.done, bus4.cout, bus4.sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run8(1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a");
        run8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add_ff_01_c");
        run8(1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run8(1'b1, 8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0, "sub_20_10");
        run8(1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1, "ignore_start");

        // Abort mid-RUN with an asynchronous reset.
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sub = 1'b0; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", bus8.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus8.busy, 0);
        chk("abort_sum", bus8.sum, 0);
        chk("abort_cout", bus8.cout, 0);
        chk("abort_done", bus8.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        donec = 0;
        for (int j = 0; j < 12; j++) begin
            if (bus8.done || bus8.busy) donec++;
            @(negedge clk);
        end
        chk("abort_no_done", donec, 0);
        run8(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

        // WIDTH=4 exhaustive at minimum request spacing.
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        av = 4'(ia); bv = 4'(ib);
                        if (s == 1) r = {1'b0, av} + {1'b0, 4'hF - bv} + 5'd1;
                        else        r = {1'b0, av} + {1'b0, bv} + 5'(c);
                        bus4.start = 1'b1; bus4.op_sub = 1'(s); bus4.cin = 1'(c);
                        bus4.a = av; bus4.b = bv;
                        @(negedge clk);
                        bus4.start = 1'b0; bus4.a = ~av; bus4.b = ~bv;
                        repeat (4) @(negedge clk);
                        chk("exh4", {bus4.done, bus4.cout, bus4.sum}, {26'd0, 1'b1, r});
                        @(negedge clk);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
